dict_codec: RTL

- Parametrised three-field dictionary codec for the compressed-instruction path.
- Holds the field1/2/3 dictionaries, loaded serially through an auto-incrementing load port.
- Serves pipelined lookups in two modes:
  - decompress: key to instruction.
  - compress: instruction to key, plus a compressible flag.
- Sits between the cache controller's compressed cache and imem. It replaces the fixed-width, externally indexed dictionary writes with a self-indexed, handshaked block.

---
 rtl/dict_codec_pkg.sv | 28 ++
 rtl/dict_field_mem.sv | 75 +++++++
 rtl/dict_codec.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dict_codec_pkg.sv
// Shared constants and helpers for the three-field dictionary codec.
// Field offsets are derived from the widths so the packing stays in one place.
package dict_codec_pkg;

  localparam logic MODE_DECOMP = 1'b0;
  localparam logic MODE_COMP   = 1'b1;

  typedef enum logic [1:0] {
    FSEL_F1   = 2'd0,
    FSEL_F2   = 2'd1,
    FSEL_F3   = 2'd2,
    FSEL_NONE = 2'd3
  } fsel_e;

  // Bit offset of field fld (0..2) in a packed key or instruction, f1 at the LSBs.
  function automatic int field_off(input int fld, input int w1, input int w2);
    case (fld)
      0:       return 0;
      1:       return w1;
      default: return w1 + w2;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dict_field_mem.sv
// One field dictionary: self-indexed serial load, indexed read and a
// lowest-index-wins parallel match over the valid entries.
module dict_field_mem
  import dict_codec_pkg::*;
#(
  parameter int KEY_W = 3,
  parameter int VAL_W = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [VAL_W-1:0] wr_data_i,
  output logic             full_o,
  input  logic [KEY_W-1:0] rd_key_i,
  output logic [VAL_W-1:0] rd_val_o,
  output logic             rd_hit_o,
  input  logic [VAL_W-1:0] match_val_i,
  output logic [KEY_W-1:0] match_key_o,
  output logic             match_hit_o
);

  localparam int DEPTH = 1 << KEY_W;

  logic [KEY_W:0]   ptr_q, ptr_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [VAL_W-1:0] mem_q [DEPTH];
  logic             wr;

  // Pointer saturates at DEPTH, so its MSB alone flags a full dictionary.
  assign full_o = ptr_q[KEY_W];
  assign wr     = wr_en_i && !full_o && !clear_i;

  always_comb begin
    ptr_d = ptr_q;
    vld_d = vld_q;
    if (clear_i) begin
      ptr_d = '0;
      vld_d = '0;
    end else if (wr) begin
      vld_d[ptr_q[KEY_W-1:0]] = 1'b1;
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_q <= '0;
      vld_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[ptr_q[KEY_W-1:0]] <= wr_data_i;
  end

  assign rd_val_o = mem_q[rd_key_i];
  assign rd_hit_o = vld_q[rd_key_i];

  // Scan downwards so the lowest matching index is the last one assigned.
  always_comb begin
    match_hit_o = 1'b0;
    match_key_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && (mem_q[i] == match_val_i)) begin
        match_hit_o = 1'b1;
        match_key_o = KEY_W'(i);
      end
    end
  end

endmodule

// File: rtl/dict_codec.sv
// Three-field dictionary codec: serial dictionary load plus a two-register
// lookup pipeline (request register, then registered lookup result).
module dict_codec
  import dict_codec_pkg::*;
#(
  parameter int F1_KEY_W = 3,
  parameter int F1_VAL_W = 7,
  parameter int F2_KEY_W = 5,
  parameter int F2_VAL_W = 10,
  parameter int F3_KEY_W = 8,
  parameter int F3_VAL_W = 15,
  localparam int IW = F1_VAL_W + F2_VAL_W + F3_VAL_W,
  localparam int KW = F1_KEY_W + F2_KEY_W + F3_KEY_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [1:0]          load_field,
  input  logic [F3_VAL_W-1:0] load_data,
  input  logic                load_clear,
  output logic                load_done,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_mode,
  input  logic [IW-1:0]       req_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IW-1:0]       resp_data,
  output logic                resp_hit,
  output logic [31:0]         stat_decomp,
  output logic [31:0]         stat_comp_hit,
  output logic [31:0]         stat_comp_miss
);

  localparam int IO2 = field_off(1, F1_VAL_W, F2_VAL_W);
  localparam int IO3 = field_off(2, F1_VAL_W, F2_VAL_W);
  localparam int KO2 = field_off(1, F1_KEY_W, F2_KEY_W);
  localparam int KO3 = field_off(2, F1_KEY_W, F2_KEY_W);

  logic full1, full2, full3, beat_fire;
  logic [F1_VAL_W-1:0] rv1;
  logic [F2_VAL_W-1:0] rv2;
  logic [F3_VAL_W-1:0] rv3;
  logic [F1_KEY_W-1:0] mk1;
  logic [F2_KEY_W-1:0] mk2;
  logic [F3_KEY_W-1:0] mk3;
  logic rh1, rh2, rh3, mh1, mh2, mh3;

  logic          s1_valid_q, s1_valid_d, s1_mode_q;
  logic [IW-1:0] s1_data_q;
  logic          s1_adv, req_fire, resp_fire;
  logic          resp_valid_q, resp_valid_d, resp_mode_q, resp_hit_q;
  logic [IW-1:0] resp_data_q, lk_data;
  logic          lk_hit;
  logic [31:0]   st_dec_q, st_hit_q, st_miss_q;

  // ---------------- load path ----------------
  always_comb begin
    case (fsel_e'(load_field))
      FSEL_F1: load_ready = !full1;
      FSEL_F2: load_ready = !full2;
      FSEL_F3: load_ready = !full3;
      default: load_ready = 1'b1;
    endcase
  end

  assign beat_fire = load_valid && load_ready && !load_clear;
  assign load_done = full1 && full2 && full3;

  dict_field_mem #(.KEY_W(F1_KEY_W), .VAL_W(F1_VAL_W)) u_f1 (
    .clk(clk), .resetn(resetn), .clear_i(load_clear),
    .wr_en_i(beat_fire && (load_field == FSEL_F1)),
    .wr_data_i(load_data[F1_VAL_W-1:0]), .full_o(full1),
    .rd_key_i(s1_data_q[F1_KEY_W-1:0]), .rd_val_o(rv1), .rd_hit_o(rh1),
    .match_val_i(s1_data_q[F1_VAL_W-1:0]), .match_key_o(mk1), .match_hit_o(mh1)
  );

  dict_field_mem #(.KEY_W(F2_KEY_W), .VAL_W(F2_VAL_W)) u_f2 (
    .clk(clk), .resetn(resetn), .clear_i(load_clear),
    .wr_en_i(beat_fire && (load_field == FSEL_F2)),
    .wr_data_i(load_data[F2_VAL_W-1:0]), .full_o(full2),
    .rd_key_i(s1_data_q[KO2 +: F2_KEY_W]), .rd_val_o(rv2), .rd_hit_o(rh2),
    .match_val_i(s1_data_q[IO2 +: F2_VAL_W]), .match_key_o(mk2), .match_hit_o(mh2)
  );

  dict_field_mem #(.KEY_W(F3_KEY_W), .VAL_W(F3_VAL_W)) u_f3 (
    .clk(clk), .resetn(resetn), .clear_i(load_clear),
    .wr_en_i(beat_fire && (load_field == FSEL_F3)),
    .wr_data_i(load_data[F3_VAL_W-1:0]), .full_o(full3),
    .rd_key_i(s1_data_q[KO3 +: F3_KEY_W]), .rd_val_o(rv3), .rd_hit_o(rh3),
    .match_val_i(s1_data_q[IO3 +: F3_VAL_W]), .match_key_o(mk3), .match_hit_o(mh3)
  );

  // ---------------- lookup pipeline ----------------
  assign s1_adv    = s1_valid_q && (!resp_valid_q || resp_ready);
  assign req_ready = load_done && (!s1_valid_q || s1_adv);
  assign req_fire  = req_valid && req_ready;
  assign resp_fire = resp_valid_q && resp_ready;

  // A clear in the lookup cycle already counts: the entries are gone next cycle.
  always_comb begin
    lk_data = '0;
    if (s1_mode_q == MODE_COMP) begin
      lk_hit = mh1 && mh2 && mh3 && !load_clear;
      if (lk_hit) lk_data[KW-1:0] = {mk3, mk2, mk1};
    end else begin
      lk_hit = rh1 && rh2 && rh3 && !load_clear;
      if (lk_hit) lk_data = {rv3, rv2, rv1};
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (req_fire)    s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;
    resp_valid_d = resp_valid_q;
    if (s1_adv)          resp_valid_d = 1'b1;
    else if (resp_ready) resp_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= MODE_DECOMP;
      s1_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_mode_q  <= MODE_DECOMP;
      resp_data_q  <= '0;
      resp_hit_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      resp_valid_q <= resp_valid_d;
      if (req_fire) begin
        s1_mode_q <= req_mode;
        s1_data_q <= req_data;
      end
      if (s1_adv) begin
        resp_mode_q <= s1_mode_q;
        resp_data_q <= lk_data;
        resp_hit_q  <= lk_hit;
      end
    end
  end

  // ---------------- statistics ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_dec_q  <= '0;
      st_hit_q  <= '0;
      st_miss_q <= '0;
    end else if (resp_fire) begin
      if (resp_mode_q == MODE_DECOMP) st_dec_q  <= sat_inc32(st_dec_q);
      else if (resp_hit_q)            st_hit_q  <= sat_inc32(st_hit_q);
      else                            st_miss_q <= sat_inc32(st_miss_q);
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign resp_hit       = resp_hit_q;
  assign stat_decomp    = st_dec_q;
  assign stat_comp_hit  = st_hit_q;
  assign stat_comp_miss = st_miss_q;

endmodule
